// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the ALU command sequencer.
//               Holds the ALU opcode encodings, the sequencer state
//               enumeration and the default datapath/register-file sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Default sizes; the downstream ALU is a fixed 4-bit part.
    localparam int SEQ_DATA_W = 4;
    localparam int SEQ_NREGS  = 4;
    localparam int SEQ_ADDR_W = 2;

    // ALU select encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_regfile
// Description : NREGS x DATA_W register file with two combinational read
//               ports and a single write path shared by the host load strobe
//               and the ALU writeback. Writeback has priority over a load to
//               the same address; loads and writebacks to different
//               addresses both take effect. Synchronous reset to zero.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_ld_en/addr/data - host load port
//               i_wb_en/addr/data - ALU writeback port
//               i_ra, i_rb        - read addresses
//               o_rd_a, o_rd_b    - read data (pre-edge contents)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS  = SEQ_NREGS,
    parameter int DATA_W = SEQ_DATA_W,
    parameter int ADDR_W = SEQ_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [ADDR_W-1:0] i_rb,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_ld_en) begin
                r_mem[i_ld_addr] <= i_ld_data;
            end
            // Issued after the load so that, on an address collision, the
            // writeback is the assignment that sticks.
            if (i_wb_en) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

    // Reads see the contents before any write at the coming edge.
    assign o_rd_a = r_mem[i_ra];
    assign o_rd_b = r_mem[i_rb];

endmodule : alu_seq_regfile
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command front-end for a 4-bit combinational ALU. Accepts
//               register-addressed commands (valid/ready), snapshots the
//               operands from the register file, drives the ALU for one
//               cycle, writes the result back and returns result/carry/zero
//               over a response valid/ready handshake.
//               IDLE -> EXEC -> RESP -> IDLE; one op per 3 cycles at best.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cmd_*                    - command handshake and fields
//               ld_en/ld_addr/ld_data    - host register load port
//               alu_a/alu_b/alu_sel      - to ALU
//               alu_result/carry/zero    - from ALU
//               rsp_*                    - response handshake and payload
//               op_count                 - saturating EXEC counter (optional)
// Options     : `define ALU_SEQ_OPCOUNT_EN adds the op_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int NREGS  = SEQ_NREGS,
    parameter int ADDR_W = SEQ_ADDR_W
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0]  op_count
`endif
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;
    logic              r_rsp_zero;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_wb_en;

    // The ALU result is only meaningful during EXEC, so that is the only
    // cycle in which it is written back.
    assign w_wb_en = (r_state == EXEC);

    alu_seq_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (r_rd),
        .i_wb_data (alu_result),
        .i_ra      (cmd_ra),
        .i_rb      (cmd_rb),
        .o_rd_a    (w_rd_a),
        .o_rd_b    (w_rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_op        <= '0;
            r_rd        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        // Operand snapshot: later loads/writebacks cannot
                        // disturb the op once it has been accepted.
                        r_op        <= cmd_op;
                        r_rd        <= cmd_rd;
                        r_opa       <= w_rd_a;
                        r_opb       <= w_rd_b;
                        r_cmd_ready <= 1'b0;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_carry <= alu_carry;
                    r_rsp_zero  <= alu_zero;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Operand registers only change on acceptance, so the ALU inputs hold
    // their last values outside EXEC without any extra enable.
    assign alu_a     = r_opa;
    assign alu_b     = r_opb;
    assign alu_sel   = r_op;
    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if ((r_state == EXEC) && (r_op_count != '1)) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule : alu_cmd_sequencer
`default_nettype wire
